// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, line levels and legal parameter ranges shared by
// the UART blocks.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

   localparam int UART_DATA_BITS_MIN = 5;
   localparam int UART_DATA_BITS_MAX = 9;
   localparam int UART_STOP_BITS_MIN = 1;
   localparam int UART_STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter. Counts 0..DIV-1 while enabled and pulses
// tick on the last count. Parked at zero while disabled so every enabled
// stretch starts on a full bit period. Written to be shared with a receiver.
module uart_baud_gen #(
   parameter int DIV = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   if (DIV < 2) begin : g_div_check
      $error("uart_baud_gen: DIV must be at least 2");
   end

   // bit-period counter, restarted by clr and held at zero when disabled
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (clr || !en) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter. One word per valid/ready
// handshake, framed as start, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits. Build option UART_TX_PARITY_EN adds the parity bit;
// without it the PARITY state and parity register are not built and
// PARITY_ODD has no effect.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line at mark, tx_ready high, waiting for tx_valid
// START  | start bit on the line for one bit period
// DATA   | data bits, LSB first, one shift per bit tick
// PARITY | parity bit for one bit period (UART_TX_PARITY_EN only)
// STOP   | STOP_BITS bit periods of mark, then back to IDLE
//
// tx is registered from the current state, so the line follows the state
// register by one clock: accept at edge N drives the start bit from N+1 and
// every bit still lasts exactly DIV clocks.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 12000000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int BC_W = $clog2(DATA_BITS + 1);

   localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
   localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

   if (DIV < 2) begin : g_div_check
      $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
   end
   if (DATA_BITS < UART_DATA_BITS_MIN || DATA_BITS > UART_DATA_BITS_MAX) begin : g_data_check
      $error("uart_tx_param: DATA_BITS out of range");
   end
   if (STOP_BITS < UART_STOP_BITS_MIN || STOP_BITS > UART_STOP_BITS_MAX) begin : g_stop_check
      $error("uart_tx_param: STOP_BITS out of range");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_par_check
      $error("uart_tx_param: PARITY_ODD must be 0 or 1");
   end

   uart_tx_state_t state, state_nxt;

   logic                 accept;
   logic                 tick;
   logic                 last_data;
   logic                 last_stop;
   logic                 tx_nxt;
   logic [BC_W-1:0]      bit_cnt;
   logic [DATA_BITS-1:0] shift_q;

`ifdef UART_TX_PARITY_EN
   logic par_q;
`endif

   assign tx_ready  = (state == IDLE);
   assign tx_busy   = !tx_ready;
   assign accept    = tx_valid && tx_ready;
   assign last_data = (bit_cnt == DATA_LAST);
   assign last_stop = (bit_cnt == STOP_LAST);

   uart_baud_gen #(
      .DIV (DIV)
   ) u_baud (
      .clk  (clk),
      .nrst (nrst),
      .en   (state != IDLE),
      .clr  (accept),
      .tick (tick)
   );

   // state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state and the line level the current state calls for
   always_comb begin
      state_nxt = state;
      tx_nxt    = UART_IDLE_LEVEL;
      case (state)
         IDLE: begin
            tx_nxt = UART_IDLE_LEVEL;
            if (accept) state_nxt = START;
         end
         START: begin
            tx_nxt = UART_START_LEVEL;
            if (tick) state_nxt = DATA;
         end
         DATA: begin
            tx_nxt = shift_q[0];
            if (tick && last_data) begin
`ifdef UART_TX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_nxt = par_q;
            if (tick) state_nxt = STOP;
         end
`endif
         STOP: begin
            tx_nxt = UART_IDLE_LEVEL;
            if (tick && last_stop) state_nxt = IDLE;
         end
         default: begin
            tx_nxt    = UART_IDLE_LEVEL;
            state_nxt = IDLE;
         end
      endcase
   end

   // bit counter: data bits, then stop bits; restarts on every state change
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         bit_cnt <= '0;
      end else if (state_nxt != state) begin
         bit_cnt <= '0;
      end else if (tick && (state == DATA || state == STOP)) begin
         bit_cnt <= bit_cnt + BC_W'(1);
      end
   end

   // shift register: load on accept, shift toward the LSB once per data bit
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         shift_q <= '0;
      end else if (accept) begin
         shift_q <= tx_data;
      end else if (state == DATA && tick) begin
         shift_q <= shift_q >> 1;
      end
   end

`ifdef UART_TX_PARITY_EN
   // parity captured from the word at accept, before the shifter consumes it
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         par_q <= 1'b0;
      end else if (accept) begin
         par_q <= (^tx_data) ^ (PARITY_ODD != 0);
      end
   end
`endif

   // registered line output; reset forces mark immediately
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tx <= UART_IDLE_LEVEL;
      end else begin
         tx <= tx_nxt;
      end
   end

endmodule
